pad_loopback_checker: RTL and testbench

//  Core-side stimulus/checker for padframe loopback bring-up. Drives a pattern onto the

---
 rtl/pad_loopback_checker.sv | 231 +++++++++++++++++++++++
 tb/tb_pad_loopback_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pad_loopback_checker.sv
// pad_loopback_checker: drives a test pattern toward the ui pads and checks the
// pattern that comes back from the uo pads LAT cycles later. Reports pass/fail,
// a saturating count of bad vectors and a sticky mask of failing lanes.
// Optional build macro PADCHK_INJECT_EN adds inject_i, which flips bit 0 of the
// driven vector (not the expected copy) so the checker can be self-tested.
module pad_loopback_checker #(
    parameter int WIDTH = 14,
    parameter int LAT   = 2,
    parameter int LEN_W = 16,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] num_vec,
    output logic [WIDTH-1:0] pat_o,
    input  logic [WIDTH-1:0] ret_i,
`ifdef PADCHK_INJECT_EN
    input  logic             inject_i,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] fail_mask
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [WIDTH-1:0] WALK_INIT = WIDTH'(1);
    localparam logic [3:0]       DRAIN_LAST = 4'(LAT - 1);

    // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Rotate left by one lane; degenerates to identity when WIDTH is 1.
    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
        rotl1 = (v << 1) | (v >> (WIDTH - 1));
    endfunction

    // Pattern generator for one vector given the per-mode running state.
    function automatic logic [WIDTH-1:0] gen_vec(
        input logic [1:0]       m,
        input logic             odd,
        input logic [WIDTH-1:0] walk,
        input logic [WIDTH-1:0] lfsr_lo
    );
        logic [15:0] chk;
        chk = 16'h5555;
        case (m)
            2'd0:    gen_vec = walk;
            2'd1:    gen_vec = lfsr_lo;
            2'd2:    gen_vec = odd ? ~chk[WIDTH-1:0] : chk[WIDTH-1:0];
            2'd3:    gen_vec = odd ? '1 : '0;
            default: gen_vec = '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [LEN_W-1:0] num_q, num_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] walk_q, walk_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [3:0]       drain_q, drain_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [LAT-1:0]   exp_vld_q, exp_vld_d;
    logic [WIDTH-1:0] exp_data_q [LAT];
    logic [WIDTH-1:0] exp_data_d [LAT];

    logic             emit_s;
    logic [WIDTH-1:0] vec_s;
    logic [WIDTH-1:0] inj_s;

    // Next-state, pattern generation, expected pipeline and checker update.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        num_d   = num_q;
        idx_d   = idx_q;
        walk_d  = walk_q;
        lfsr_d  = lfsr_q;
        drain_d = drain_q;
        err_d   = err_q;
        mask_d  = mask_q;
        emit_s  = 1'b0;
        vec_s   = '0;
        inj_s   = '0;

        // Oldest expected stage lines up with the ret_i sample on this edge.
        if (exp_vld_q[LAT-1] && (ret_i != exp_data_q[LAT-1])) begin
            mask_d = mask_q | (ret_i ^ exp_data_q[LAT-1]);
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            mask_d = mask_q;
            err_d  = err_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d = mode;
                    num_d  = num_vec;
                    err_d  = '0;
                    mask_d = '0;
                    if (num_vec == '0) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                        walk_d  = WALK_INIT;
                        lfsr_d  = LFSR_SEED;
                    end else begin
                        // Vector 0 goes out on the accepting edge itself.
                        state_d = S_DRIVE;
                        emit_s  = 1'b1;
                        vec_s   = gen_vec(mode, 1'b0, WALK_INIT, LFSR_SEED[WIDTH-1:0]);
                        idx_d   = LEN_W'(1);
                        walk_d  = rotl1(WALK_INIT);
                        lfsr_d  = lfsr_step(LFSR_SEED);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DRIVE: begin
                if (idx_q == num_q) begin
                    state_d = S_DRAIN;
                    drain_d = 4'd0;
                end else begin
                    emit_s = 1'b1;
                    vec_s  = gen_vec(mode_q, idx_q[0], walk_q, lfsr_q[WIDTH-1:0]);
                    idx_d  = idx_q + 1'b1;
                    walk_d = rotl1(walk_q);
                    lfsr_d = lfsr_step(lfsr_q);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PADCHK_INJECT_EN
        inj_s[0] = inject_i & emit_s;
`endif
        pat_d = emit_s ? (vec_s ^ inj_s) : '0;

        exp_vld_d[0]  = emit_s;
        exp_data_d[0] = vec_s;
        for (int i = 1; i < LAT; i++) begin
            exp_vld_d[i]  = exp_vld_q[i-1];
            exp_data_d[i] = exp_data_q[i-1];
        end

        busy_d = (state_d == S_DRIVE) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            num_q     <= '0;
            idx_q     <= '0;
            walk_q    <= WALK_INIT;
            lfsr_q    <= LFSR_SEED;
            drain_q   <= 4'd0;
            pat_q     <= '0;
            err_q     <= '0;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            exp_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                exp_data_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            walk_q    <= walk_d;
            lfsr_q    <= lfsr_d;
            drain_q   <= drain_d;
            pat_q     <= pat_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            exp_vld_q <= exp_vld_d;
            for (int i = 0; i < LAT; i++) begin
                exp_data_q[i] <= exp_data_d[i];
            end
        end
    end

    assign pat_o     = pat_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_pad_loopback_checker.sv
// Directed bench for pad_loopback_checker. The loopback counts the DUT's own
// pat_o flop as the first of the LAT round-trip stages, so vector k driven after
// edge E0+k is on ret_i when the DUT samples it at edge E0+k+LAT.
module tb_pad_loopback_checker;

    localparam int WIDTH = 14;
    localparam int LAT   = 2;
    localparam int LEN_W = 16;
    localparam int ERR_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [LEN_W-1:0] num_vec;
    logic [WIDTH-1:0] pat_o;
    logic [WIDTH-1:0] ret_i;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [WIDTH-1:0] fail_mask;
`ifdef PADCHK_INJECT_EN
    logic             inject_i;
`endif

    logic [WIDTH-1:0] lb_q;
    logic [WIDTH-1:0] ret_keep;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    always #5 clk = ~clk;

    // Remaining LAT-1 loopback stage between pat_o and ret_i.
    always_ff @(posedge clk) lb_q <= pat_o;

    assign ret_i = lb_q & ret_keep;

    pad_loopback_checker #(
        .WIDTH(WIDTH), .LAT(LAT), .LEN_W(LEN_W), .ERR_W(ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .num_vec   (num_vec),
        .pat_o     (pat_o),
        .ret_i     (ret_i),
`ifdef PADCHK_INJECT_EN
        .inject_i  (inject_i),
`endif
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_mask (fail_mask)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; afterwards the DUT is just past E0.
    task automatic kick(input logic [1:0] m, input logic [LEN_W-1:0] n);
        mode    = m;
        num_vec = n;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Count sampled busy cycles (starting from 'already'), bounded.
    task automatic wait_idle(input int already, output int count);
        count = already;
        while (busy === 1'b1 && count < 5000) begin
            count++;
            tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 2'd0;
        num_vec  = 16'd0;
        ret_keep = '1;
`ifdef PADCHK_INJECT_EN
        inject_i = 1'b0;
`endif
        tick();
        tick();
        chk("rst_pat",  32'(pat_o),     32'h0);
        chk("rst_busy", 32'(busy),      32'h0);
        chk("rst_done", 32'(done),      32'h0);
        chk("rst_pass", 32'(pass),      32'h0);
        chk("rst_err",  32'(err_cnt),   32'h0);
        chk("rst_mask", 32'(fail_mask), 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);

        // 1: walking one, 20 vectors, wraps after lane 13.
        kick(2'd0, 16'd20);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("t1_pat%0d", k), 32'(pat_o), 32'(14'd1 << (k % 14)));
            chk($sformatf("t1_busy%0d", k), 32'(busy), 32'h1);
            tick();
        end
        chk("t1_drain_pat", 32'(pat_o), 32'h0);
        chk("t1_drain_busy", 32'(busy), 32'h1);
        tick();
        chk("t1_notdone21", 32'(done), 32'h0);
        tick();
        chk("t1_done",  32'(done),      32'h1);
        chk("t1_busy",  32'(busy),      32'h0);
        chk("t1_pass",  32'(pass),      32'h1);
        chk("t1_err",   32'(err_cnt),   32'h0);
        chk("t1_mask",  32'(fail_mask), 32'h0);

        // 2: LFSR, 1000 vectors; first vectors hand-stepped from 0xACE1.
        kick(2'd1, 16'd1000);
        chk("t2_v0", 32'(pat_o), 32'h2CE1);
        tick();
        chk("t2_v1", 32'(pat_o), 32'h1670);
        tick();
        chk("t2_v2", 32'(pat_o), 32'h2B38);
        tick();
        chk("t2_v3", 32'(pat_o), 32'h159C);
        wait_idle(3, cyc);
        chk("t2_busy_cycles", 32'(cyc), 32'd1002);
        chk("t2_done", 32'(done),    32'h1);
        chk("t2_pass", 32'(pass),    32'h1);
        chk("t2_err",  32'(err_cnt), 32'h0);

        // 3: checkerboard, 8 vectors, lane 5 stuck low on return.
        ret_keep = 14'h3FDF;
        kick(2'd2, 16'd8);
        chk("t3_v0", 32'(pat_o), 32'h1555);
        tick();
        chk("t3_v1", 32'(pat_o), 32'h2AAA);
        wait_idle(1, cyc);
        chk("t3_busy_cycles", 32'(cyc), 32'd10);
        chk("t3_done", 32'(done),      32'h1);
        chk("t3_err",  32'(err_cnt),   32'd4);
        chk("t3_mask", 32'(fail_mask), 32'h0020);
        chk("t3_pass", 32'(pass),      32'h0);
        ret_keep = '1;

        // 4a: empty run finishes on the accepting edge and clears old errors.
        kick(2'd3, 16'd0);
        chk("t4_done", 32'(done),      32'h1);
        chk("t4_busy", 32'(busy),      32'h0);
        chk("t4_pass", 32'(pass),      32'h1);
        chk("t4_err",  32'(err_cnt),   32'h0);
        chk("t4_mask", 32'(fail_mask), 32'h0);

        // 4b: mode3, 10 vectors; a second start at k=3 with other settings is ignored.
        kick(2'd3, 16'd10);
        chk("t4_v0", 32'(pat_o), 32'h0000);
        chk("t4_notdone", 32'(done), 32'h0);
        tick();
        chk("t4_v1", 32'(pat_o), 32'h3FFF);
        tick();
        chk("t4_v2", 32'(pat_o), 32'h0000);
        mode    = 2'd0;
        num_vec = 16'd3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("t4_v3_ignored_start", 32'(pat_o), 32'h3FFF);
        wait_idle(3, cyc);
        chk("t4_busy_cycles", 32'(cyc), 32'd12);
        chk("t4b_pass", 32'(pass), 32'h1);

        // 5: reset (with a simultaneous start) at k=5 of a 50-vector run.
        kick(2'd0, 16'd50);
        for (int k = 0; k < 5; k++) tick();
        chk("t5_v5", 32'(pat_o), 32'h0020);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("t5_pat",  32'(pat_o),     32'h0);
        chk("t5_busy", 32'(busy),      32'h0);
        chk("t5_done", 32'(done),      32'h0);
        chk("t5_pass", 32'(pass),      32'h0);
        chk("t5_err",  32'(err_cnt),   32'h0);
        chk("t5_mask", 32'(fail_mask), 32'h0);
        tick();
        chk("t5_stays_idle", 32'(busy), 32'h0);
        kick(2'd2, 16'd5);
        chk("t5_new_v0", 32'(pat_o), 32'h1555);
        wait_idle(0, cyc);
        chk("t5_busy_cycles", 32'(cyc), 32'd7);
        chk("t5_done2", 32'(done), 32'h1);
        chk("t5_pass2", 32'(pass), 32'h1);

`ifdef PADCHK_INJECT_EN
        // 6: deliberate bit-0 flip on vector 1 of a mode3 run.
        kick(2'd3, 16'd6);
        inject_i = 1'b1;
        tick();
        inject_i = 1'b0;
        chk("t6_v1_injected", 32'(pat_o), 32'h3FFE);
        wait_idle(1, cyc);
        chk("t6_err",  32'(err_cnt),   32'd1);
        chk("t6_mask", 32'(fail_mask), 32'h0001);
        chk("t6_pass", 32'(pass),      32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
